// File: rtl/debounce_sync_if.sv
// Signal bundle between a raw-input consumer and the debounce/synchronizer block.
// The master drives the raw input and the slave returns the conditioned level and edge pulses.
interface debounce_sync_if;
  logic din;
  logic dout;
  logic rise;
  logic fall;
  logic busy;

  modport master (output din, input dout, rise, fall, busy);
  modport slave  (input din, output dout, rise, fall, busy);
endinterface

// File: rtl/debounce_sync.sv
// Synchronizes an asynchronous raw input, qualifies each level change over a run of stable samples,
// and emits a registered level plus single-cycle rise/fall pulses.
module debounce_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 16,
  parameter int STABLE_CYCLES = 1000
) (
  input  logic            clk,
  input  logic            reset,
  debounce_sync_if.slave  dbi
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   dout_q, rise_q, fall_q, busy_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], dbi.din};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Pulses default low every cycle so they can only last the one cycle after a commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE_LO;
      cnt    <= '0;
      dout_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state)
        IDLE_LO: if (s) begin
          state  <= WAIT_HI;
          cnt    <= CNT_W'(1);
          busy_q <= 1'b1;
        end
        WAIT_HI: if (!s) begin
          state  <= IDLE_LO;
          cnt    <= '0;
          busy_q <= 1'b0;
        end else if (cnt == LAST) begin
          state  <= IDLE_HI;
          cnt    <= '0;
          dout_q <= 1'b1;
          rise_q <= 1'b1;
          busy_q <= 1'b0;
        end else begin
          cnt    <= cnt + CNT_W'(1);
        end
        IDLE_HI: if (!s) begin
          state  <= WAIT_LO;
          cnt    <= CNT_W'(1);
          busy_q <= 1'b1;
        end
        WAIT_LO: if (s) begin
          state  <= IDLE_HI;
          cnt    <= '0;
          busy_q <= 1'b0;
        end else if (cnt == LAST) begin
          state  <= IDLE_LO;
          cnt    <= '0;
          dout_q <= 1'b0;
          fall_q <= 1'b1;
          busy_q <= 1'b0;
        end else begin
          cnt    <= cnt + CNT_W'(1);
        end
        default: begin
          state  <= IDLE_LO;
          cnt    <= '0;
          dout_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign dbi.dout = dout_q;
  assign dbi.rise = rise_q;
  assign dbi.fall = fall_q;
  assign dbi.busy = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed and randomized bench for debounce_sync; outputs are compared every cycle against a
// run-length reference model fed through a sample-delay queue.
module tb_debounce_sync;
  localparam int SS = 2;
  localparam int SC = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  debounce_sync_if dbi();

  debounce_sync #(.SYNC_STAGES(SS), .CNT_W(16), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .dbi(dbi)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // Reference: s is din delayed SS edges; dout flips after SC consecutive samples disagree with it.
  logic dq[$];
  int   m_run = 0;
  logic m_dout = 0, m_rise = 0, m_fall = 0, m_busy = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic d, input logic r);
    logic s;
    dbi.din = d;
    reset = r;
    @(posedge clk);
    m_rise = 0;
    m_fall = 0;
    if (r) begin
      dq = {};
      for (int i = 0; i < SS; i++) dq.push_back(1'b0);
      m_run = 0;
      m_dout = 0;
    end else begin
      s = dq.pop_front();
      dq.push_back(d);
      if (s != m_dout) begin
        m_run++;
        if (m_run == SC) begin
          m_dout = s;
          m_rise = s;
          m_fall = !s;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    m_busy = (m_run != 0);
    #1;
    chk("dout", dbi.dout, m_dout);
    chk("rise", dbi.rise, m_rise);
    chk("fall", dbi.fall, m_fall);
    chk("busy", dbi.busy, m_busy);
    chk("rise_fall_excl", dbi.rise & dbi.fall, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise_at, fall_at, n_rise, n_fall, n_busy, hold;
    logic lvl;
    dbi.din = 1'b0;

    // 1: reset with din low, then idle
    repeat (3) step(1'b0, 1'b1);
    repeat (20) step(1'b0, 1'b0);

    // 2: clean rise
    rise_at = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0);
      if (i == 3) chk("t2_busy_e2", dbi.busy, 1);
      if (i == 6) begin
        chk("t2_dout_e5", dbi.dout, 1);
        chk("t2_busy_e5", dbi.busy, 0);
      end
      if (i == 7) chk("t2_rise_e6", dbi.rise, 0);
      if (dbi.rise && rise_at == 0) rise_at = i;
    end
    chk("t2_rise_lat", rise_at, 6);

    // 3: bounce before settling high
    step(1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0);
    n_rise = 0; rise_at = 0;
    repeat (2) begin step(1'b1, 1'b0); n_rise += dbi.rise; end
    step(1'b0, 1'b0); n_rise += dbi.rise;
    chk("t3_no_rise_bounce", n_rise, 0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0);
      n_rise += dbi.rise;
      if (dbi.rise && rise_at == 0) rise_at = i;
    end
    chk("t3_rise_lat", rise_at, 6);
    chk("t3_rise_cnt", n_rise, 1);
    chk("t3_dout", dbi.dout, 1);

    // 4: clean fall from dout=1
    n_rise = 0; n_fall = 0; fall_at = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b0);
      n_rise += dbi.rise;
      n_fall += dbi.fall;
      if (dbi.fall && fall_at == 0) fall_at = i;
    end
    chk("t4_fall_lat", fall_at, 6);
    chk("t4_fall_cnt", n_fall, 1);
    chk("t4_rise_cnt", n_rise, 0);
    chk("t4_dout", dbi.dout, 0);

    // 5: glitch one sample short of qualifying
    n_rise = 0; n_busy = 0;
    repeat (3) begin step(1'b1, 1'b0); n_busy += dbi.busy; n_rise += dbi.rise; end
    repeat (10) begin step(1'b0, 1'b0); n_busy += dbi.busy; n_rise += dbi.rise; end
    chk("t5_busy_cycles", n_busy, 3);
    chk("t5_rise_cnt", n_rise, 0);
    chk("t5_dout", dbi.dout, 0);

    // 6: reset mid-qualification, released with din still high
    repeat (4) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("t6_dout_rst", dbi.dout, 0);
    chk("t6_busy_rst", dbi.busy, 0);
    rise_at = 0;
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 1'b0);
      if (dbi.rise && rise_at == 0) rise_at = i;
    end
    chk("t6_rise_lat", rise_at, 6);

    // random bursts with occasional reset
    lvl = 1'b0;
    for (int k = 0; k < 700; k++) begin
      lvl = ~lvl;
      hold = $urandom_range(1, 7);
      if ($urandom_range(0, 49) == 0) begin
        repeat ($urandom_range(1, 2)) step(lvl, 1'b1);
      end
      repeat (hold) step(lvl, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Conditions a raw asynchronous input (push-button, external strobe) into a clean, clock-synchronous level plus single-cycle edge pulses.
- Sits directly upstream of the design's D flip-flop stages; its outputs drive their d/enable inputs.
- Structure: multi-stage synchronizer, then a stability counter/FSM, then registered edge pulses.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on din (legal range 2..4)
CNT_W, 16, width of stability counter
STABLE_CYCLES, 1000, consecutive synchronized samples required before dout changes (legal 2..2^CNT_W-1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
din  input  1  raw asynchronous input, may bounce
dout  output  1  debounced level, registered
rise  output  1  one-cycle pulse, registered, when dout goes 0->1
fall  output  1  one-cycle pulse, registered, when dout goes 1->0
busy  output  1  high while a candidate transition is being qualified (FSM in WAIT_HI/WAIT_LO)

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk. All state updates occur on posedge clk only. No async paths.
- Reset (sampled high at an edge): sync chain <= 0, cnt <= 0, state <= IDLE_LO, dout/rise/fall/busy <= 0. Reset takes priority over all other activity, including mid-qualification and mid-pulse.
- Synchronizer: din shifts through SYNC_STAGES flops; s = last stage output. The FSM observes only s.
- FSM states: IDLE_LO (dout=0), WAIT_HI, IDLE_HI (dout=1), WAIT_LO.
- IDLE_LO:
  - s==1 -> WAIT_HI, cnt<=1.
  - else stay.
- WAIT_HI:
  - s==1 and cnt==STABLE_CYCLES-1 -> IDLE_HI, dout<=1, rise<=1, cnt<=0.
  - s==1 otherwise -> cnt<=cnt+1.
  - s==0 -> IDLE_LO, cnt<=0, no pulse.
- IDLE_HI / WAIT_LO: mirror of IDLE_LO / WAIT_HI with s==0 as the target; commit drives dout<=0, fall<=1.
- Qualification rule: dout changes only after exactly STABLE_CYCLES consecutive edges sample s at the new value. A single opposite sample aborts the attempt and restarts the count from zero.
- rise/fall: high for exactly one cycle following the commit edge, otherwise 0. They are never high simultaneously. A back-to-back pulse is impossible: minimum spacing between pulses is STABLE_CYCLES cycles.
- busy: 1 in the cycle following any edge that leaves the FSM in WAIT_HI or WAIT_LO; 0 in the IDLE states.
- Latency: din changes and is held before edge E0. dout, rise or fall update at edge E0+SYNC_STAGES+STABLE_CYCLES-1 (E0+5 for 2/4).
- Counter: never exceeds STABLE_CYCLES-1, so no wrap-around is possible. cnt is unsigned, CNT_W bits.
- Reset released with din already high: the FSM starts in IDLE_LO and qualifies high with full latency; rise pulses at the commit.

Test Plan (SYNC_STAGES=2, STABLE_CYCLES=4, din changes just after edge E0-1):
1. Reset held 3 cycles, din=0 -> dout=0, rise=0, fall=0, busy=0 throughout; after release, all outputs stay 0 for 20 cycles.
2. din 0->1, held -> busy=1 after E0+2; dout=1 and rise=1 after E0+5; rise=0 after E0+6; busy=0 after E0+5.
3. Bounce: din=1 for 2 cycles, 0 for 1 cycle, then 1 held -> no rise during the bounce; rise and dout=1 occur exactly 6 edges after the final 0->1 change; exactly one rise pulse total.
4. dout=1 steady, din 1->0 held -> fall=1 and dout=0 after E0+5; rise stays 0 throughout; single fall pulse.
5. Glitch: din high for exactly 3 cycles (one short of qualifying) -> dout stays 0, no pulses; busy high 3 cycles, then 0.
6. Reset mid-qualification: din high, reset asserted at E0+4 -> dout=0, busy=0, cnt=0 after E0+4. Deassert reset with din still high -> dout=1 and rise after a further full 6-edge latency from release.
